forward_unit: RTL and testbench
===============================

Name: forward_unit

Overview:
- Forwarding and hazard controller for the 5-stage LC-3b pipeline. It is the producer of the opA, opB and store-source forwarding selects that the execute stage consumes.
- Tracks destination and writeback state of in-flight instructions in a private 2-slot scoreboard (EX, MEM).
- Computes registered forwarding selects for the instruction entering EX.
- Raises a load-use stall that holds IF/ID and injects a bubble into EX.

Parameters:
- REG_W, 3, register index width (R0-R7).
- SEL_W, 2, forwarding select width.

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- advance  in  1  pipeline registers load this cycle; low during cache/memory stalls
- flush  in  1  taken branch/jump resolved; squashes the instructions currently in ID and EX at this advance
- id_valid  in  1  ID slot holds a real instruction
- id_sr1  in  REG_W  opA source register
- id_sr1_used  in  1  opA reads a register
- id_sr2  in  REG_W  opB source register
- id_sr2_used  in  1  opB is a register (alumux selects sr2); 0 means immediate
- id_srst  in  REG_W  store-data source register
- id_srst_used  in  1  instruction is a store needing sr_store
- id_dest  in  REG_W  destination register
- id_regwrite  in  1  instruction writes the register file
- id_is_load  in  1  LDR/LDB/LDI: result valid only at WB
- opAmux_sel  out  SEL_W  registered; 00 regfile, 01 MEM forward, 10 WB forward, 11 zero (never driven)
- opBmux_sel  out  SEL_W  same encoding
- opSrmux_sel  out  SEL_W  same encoding
- stall_id  out  1  combinational; hold PC and IF/ID, bubble into EX

Behaviour:
- **Scoreboard.** Slot ex = {valid, dest, regwrite, is_load} of the instruction now in EX. Slot mem = {valid, dest, regwrite} of the instruction now in MEM.
- **Reset (async, reset_n=0).** All slot valids 0, regwrite 0. All three selects 00. stall_id therefore 0.
- **stall_id** = id_valid & ex.valid & ex.regwrite & ex.is_load & ~flush & any of:
  - id_sr1_used & id_sr1==ex.dest
  - id_sr2_used & id_sr2==ex.dest
  - id_srst_used & id_srst==ex.dest
- **advance=0.** Slots and selects hold unchanged. stall_id still evaluates and may be 1.
- **advance=1, normal** (no flush, no stall):
  - mem <= ex (is_load dropped).
  - ex <= ID fields with valid=id_valid; regwrite gated by id_valid.
  - Each select is registered from the operand's used bit and its source register:
    - 01 if used & ex.valid & ex.regwrite & ~ex.is_load & src==ex.dest (producer moves to MEM).
    - Else 10 if used & mem.valid & mem.regwrite & src==mem.dest (producer moves to WB).
    - Else 00.
  - MEM has priority over WB: it is the youngest producer.
  - used=0 forces 00, so an immediate opB always selects alumux_out.
- **advance=1, stall_id=1:**
  - mem <= ex.
  - ex <= bubble (valid 0, regwrite 0).
  - Selects <= 00.
  - On the following advance the load sits in MEM slot → WB forward (10).
- **advance=1, flush=1:**
  - ex <= bubble.
  - mem <= bubble (EX instruction squashed).
  - Selects <= 00.
  - flush overrides stall.
- **WB→ID same-cycle hazard** is handled by the write-through register file, not by this block.
- **Match semantics.** R0 is an ordinary register; no index is excluded from matching. One instruction may hit on several operands with different selects.
- **Latency.** Selects are valid the cycle after the advance that loads the consumer into EX, and remain stable while advance=0.

Decomposition:
- Add to lc3b_types:
  - lc3b_reg (3-bit).
  - Enum lc3b_fwd_sel with FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10, FWD_ZERO=2'b11.
  - Struct lc3b_sb_entry {valid, dest, regwrite, is_load}.
- One sub-module, fwd_sel_calc: combinational compare of (used, src) against the ex and mem entries, returning lc3b_fwd_sel and a load-hit flag. Instantiated three times.

Test Plan:
- **Back-to-back forward to MEM.** ADD R1 into EX, then ADD R2,R1,R3 advances into EX → opAmux_sel=01, opBmux_sel=00. After one more advance with a non-dependent op → selects 00.
- **Distance-2 forward to WB.** ADD R4 writes; the next instruction is independent; the third uses R4 as sr2 (register mode) → opBmux_sel=10. Same with id_sr2_used=0 → opBmux_sel=00.
- **Load-use stall.** LDR R5 in EX; ID has STR with srst=R5 → stall_id=1, one bubble, then opSrmux_sel=10 for the STR. Selects stay 00 during the bubble cycle.
- **Priority and hold.** R6 written by both MEM and EX producers; consumer sr1=R6 → opAmux_sel=01. Hold advance=0 for 5 cycles → selects and stall_id unchanged. Release advance → normal progress.
- **Flush over stall.** Load-use condition present with flush=1 at an advance → stall_id=0; ex and mem slots invalid. Next consumer of that register gets select 00.
- **Async reset mid-stall.** Drop reset_n between clock edges → selects 00 and stall_id 0 immediately. After release with id_valid=0 the first advance yields no forwarding.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: register index, forwarding select encoding and
// the scoreboard entries the forwarding unit keeps for the EX and MEM stages.
package lc3b_types;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10,
    FWD_ZERO = 2'b11
  } lc3b_fwd_sel;

  typedef struct packed {
    logic    valid;
    lc3b_reg dest;
    logic    regwrite;
    logic    is_load;
  } lc3b_sb_entry;

  // MEM never needs is_load: a load there is forwarded from WB like any result.
  typedef struct packed {
    logic    valid;
    lc3b_reg dest;
    logic    regwrite;
  } lc3b_mem_entry;

  localparam lc3b_sb_entry  SB_BUBBLE  = '0;
  localparam lc3b_mem_entry MEM_BUBBLE = '0;

endpackage

// File: rtl/fwd_sel_calc.sv
// Combinational: one operand's source vs the EX/MEM producers -> forward select
// (youngest producer wins) plus a flag when the EX producer is a load (must stall).
module fwd_sel_calc
  import lc3b_types::*;
(
  input  logic          used,
  input  lc3b_reg       src,
  input  lc3b_sb_entry  ex_ent,
  input  lc3b_mem_entry mem_ent,
  output lc3b_fwd_sel   sel,
  output logic          load_hit
);

  logic ex_match;
  logic mem_match;

  assign ex_match  = used & ex_ent.valid & ex_ent.regwrite & (src == ex_ent.dest);
  assign mem_match = used & mem_ent.valid & mem_ent.regwrite & (src == mem_ent.dest);
  assign load_hit  = ex_match & ex_ent.is_load;

  always_comb begin
    sel = FWD_RF;
    if (ex_match && !ex_ent.is_load) begin
      sel = FWD_MEM;
    end else if (mem_match) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/forward_unit.sv
// Forwarding/hazard control: registered opA/opB/store selects one cycle after the
// consumer enters EX; state holds while advance=0; load-use raises stall_id combinationally.
module forward_unit
  import lc3b_types::*;
#(
  parameter int REG_W = 3,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             advance,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_sr1,
  input  logic             id_sr1_used,
  input  logic [REG_W-1:0] id_sr2,
  input  logic             id_sr2_used,
  input  logic [REG_W-1:0] id_srst,
  input  logic             id_srst_used,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_regwrite,
  input  logic             id_is_load,
  output logic [SEL_W-1:0] opAmux_sel,
  output logic [SEL_W-1:0] opBmux_sel,
  output logic [SEL_W-1:0] opSrmux_sel,
  output logic             stall_id
);

  lc3b_sb_entry  ex_q, ex_d;
  lc3b_mem_entry mem_q, mem_d;
  lc3b_fwd_sel   sel_a_q, sel_a_d, sel_b_q, sel_b_d, sel_s_q, sel_s_d;
  lc3b_fwd_sel   calc_a, calc_b, calc_s;
  logic          hit_a, hit_b, hit_s;

  fwd_sel_calc u_calc_a (
    .used(id_sr1_used), .src(lc3b_reg'(id_sr1)), .ex_ent(ex_q), .mem_ent(mem_q),
    .sel(calc_a), .load_hit(hit_a)
  );
  fwd_sel_calc u_calc_b (
    .used(id_sr2_used), .src(lc3b_reg'(id_sr2)), .ex_ent(ex_q), .mem_ent(mem_q),
    .sel(calc_b), .load_hit(hit_b)
  );
  fwd_sel_calc u_calc_s (
    .used(id_srst_used), .src(lc3b_reg'(id_srst)), .ex_ent(ex_q), .mem_ent(mem_q),
    .sel(calc_s), .load_hit(hit_s)
  );

  // A flushed ID instruction never reaches EX, so it cannot cause a stall.
  assign stall_id = id_valid & ~flush & (hit_a | hit_b | hit_s);

  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    sel_s_d = sel_s_q;
    if (advance) begin
      if (flush) begin
        ex_d    = SB_BUBBLE;
        mem_d   = MEM_BUBBLE;
        sel_a_d = FWD_RF;
        sel_b_d = FWD_RF;
        sel_s_d = FWD_RF;
      end else begin
        mem_d = '{valid: ex_q.valid, dest: ex_q.dest, regwrite: ex_q.regwrite};
        if (stall_id) begin
          ex_d    = SB_BUBBLE;
          sel_a_d = FWD_RF;
          sel_b_d = FWD_RF;
          sel_s_d = FWD_RF;
        end else begin
          ex_d = '{valid: id_valid, dest: lc3b_reg'(id_dest),
                   regwrite: id_regwrite & id_valid, is_load: id_is_load};
          sel_a_d = calc_a;
          sel_b_d = calc_b;
          sel_s_d = calc_s;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q    <= SB_BUBBLE;
      mem_q   <= MEM_BUBBLE;
      sel_a_q <= FWD_RF;
      sel_b_q <= FWD_RF;
      sel_s_q <= FWD_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      sel_s_q <= sel_s_d;
    end
  end

  assign opAmux_sel  = SEL_W'(sel_a_q);
  assign opBmux_sel  = SEL_W'(sel_b_q);
  assign opSrmux_sel = SEL_W'(sel_s_q);

endmodule

// File: tb/tb_forward_unit.sv
// Directed bench for forward_unit: hand-computed selects and stall after each step.
module tb_forward_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       advance;
  logic       flush;
  logic       id_valid;
  logic [2:0] id_sr1, id_sr2, id_srst, id_dest;
  logic       id_sr1_used, id_sr2_used, id_srst_used, id_regwrite, id_is_load;
  logic [1:0] opAmux_sel, opBmux_sel, opSrmux_sel;
  logic       stall_id;

  int total_cnt = 0;
  int pass_cnt  = 0;

  forward_unit #(.REG_W(3), .SEL_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .advance(advance), .flush(flush),
    .id_valid(id_valid),
    .id_sr1(id_sr1), .id_sr1_used(id_sr1_used),
    .id_sr2(id_sr2), .id_sr2_used(id_sr2_used),
    .id_srst(id_srst), .id_srst_used(id_srst_used),
    .id_dest(id_dest), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .opAmux_sel(opAmux_sel), .opBmux_sel(opBmux_sel), .opSrmux_sel(opSrmux_sel),
    .stall_id(stall_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v,
                        input logic [2:0] s1, input logic u1,
                        input logic [2:0] s2, input logic u2,
                        input logic [2:0] ss, input logic us,
                        input logic [2:0] d, input logic rw, input logic ld);
    id_valid = v;
    id_sr1 = s1;  id_sr1_used = u1;
    id_sr2 = s2;  id_sr2_used = u2;
    id_srst = ss; id_srst_used = us;
    id_dest = d;  id_regwrite = rw; id_is_load = ld;
    #1;
  endtask

  // One clock with the given advance; outputs sampled 1ns after the edge.
  task automatic step(input logic adv);
    advance = adv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    advance = 1'b0;
    flush   = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("reset_opA", opAmux_sel, 2'b00);
    chk("reset_opB", opBmux_sel, 2'b00);
    chk("reset_opSr", opSrmux_sel, 2'b00);
    chk("reset_stall", {1'b0, stall_id}, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back: ADD R1 ; ADD R2,R1,R3 ; independent op.
    set_id(1, 3'd2, 1, 3'd3, 1, 3'd0, 0, 3'd1, 1, 0);
    step(1);
    set_id(1, 3'd1, 1, 3'd3, 1, 3'd0, 0, 3'd2, 1, 0);
    step(1);
    chk("b2b_opA_mem", opAmux_sel, 2'b01);
    chk("b2b_opB_rf", opBmux_sel, 2'b00);
    chk("b2b_opSr_rf", opSrmux_sel, 2'b00);
    set_id(1, 3'd5, 1, 3'd6, 1, 3'd0, 0, 3'd7, 1, 0);
    step(1);
    chk("b2b_next_opA", opAmux_sel, 2'b00);
    chk("b2b_next_opB", opBmux_sel, 2'b00);

    // Distance 2: ADD R4 ; independent ; consumer sr2=R4, register then immediate.
    for (int k = 0; k < 2; k++) begin
      set_id(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 3'd4, 1, 0);
      step(1);
      set_id(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 1, 0);
      step(1);
      set_id(1, 3'd1, 1, 3'd4, (k == 0), 3'd0, 0, 3'd3, 1, 0);
      step(1);
      chk(k == 0 ? "dist2_opB_wb" : "dist2_imm_opB_rf", opBmux_sel, (k == 0) ? 2'b10 : 2'b00);
      chk("dist2_opA_rf", opAmux_sel, 2'b00);
    end

    // Load-use: LDR R5 ; STR with srst=R5.
    set_id(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 3'd5, 1, 1);
    step(1);
    set_id(1, 3'd6, 1, 3'd0, 0, 3'd5, 1, 3'd0, 0, 0);
    chk("lu_stall_hi", {1'b0, stall_id}, 2'b01);
    step(1);
    chk("lu_bubble_opA", opAmux_sel, 2'b00);
    chk("lu_bubble_opSr", opSrmux_sel, 2'b00);
    chk("lu_stall_cleared", {1'b0, stall_id}, 2'b00);
    step(1);
    chk("lu_str_opSr_wb", opSrmux_sel, 2'b10);
    chk("lu_str_opA_rf", opAmux_sel, 2'b00);

    // Priority: two R6 producers, consumer sr1=R6 takes the younger (MEM).
    set_id(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 3'd6, 1, 0);
    step(1);
    step(1);
    set_id(1, 3'd6, 1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 0);
    step(1);
    chk("prio_opA_mem", opAmux_sel, 2'b01);
    set_id(1, 3'd1, 1, 3'd6, 1, 3'd0, 0, 3'd2, 1, 0);
    for (int c = 0; c < 5; c++) begin
      step(0);
      chk("hold_opA", opAmux_sel, 2'b01);
      chk("hold_opB", opBmux_sel, 2'b00);
      chk("hold_stall", {1'b0, stall_id}, 2'b00);
    end
    step(1);
    chk("release_opA_mem", opAmux_sel, 2'b01);
    chk("release_opB_wb", opBmux_sel, 2'b10);

    // Flush overrides a load-use stall.
    set_id(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 3'd3, 1, 1);
    step(1);
    set_id(1, 3'd3, 1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 0);
    chk("flush_pre_stall", {1'b0, stall_id}, 2'b01);
    flush = 1'b1;
    #1;
    chk("flush_stall_low", {1'b0, stall_id}, 2'b00);
    step(1);
    flush = 1'b0;
    chk("flush_opA_rf", opAmux_sel, 2'b00);
    set_id(1, 3'd3, 1, 3'd3, 1, 3'd3, 1, 3'd4, 1, 0);
    chk("flush_after_stall", {1'b0, stall_id}, 2'b00);
    step(1);
    chk("flush_consumer_opA", opAmux_sel, 2'b00);
    chk("flush_consumer_opB", opBmux_sel, 2'b00);
    chk("flush_consumer_opSr", opSrmux_sel, 2'b00);

    // Async reset mid-stall: LDR R5 (sr1=R4 from EX) ; consumer sr2=R5.
    set_id(1, 3'd4, 1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 1);
    step(1);
    chk("ar_pre_opA_mem", opAmux_sel, 2'b01);
    set_id(1, 3'd0, 0, 3'd5, 1, 3'd0, 0, 3'd1, 1, 0);
    chk("ar_pre_stall", {1'b0, stall_id}, 2'b01);
    #1;
    reset_n = 1'b0;
    #1;
    chk("ar_opA_cleared", opAmux_sel, 2'b00);
    chk("ar_stall_cleared", {1'b0, stall_id}, 2'b00);
    #1;
    reset_n = 1'b1;
    set_id(0, 3'd5, 1, 3'd5, 1, 3'd5, 1, 3'd5, 1, 0);
    step(1);
    chk("ar_post_opA", opAmux_sel, 2'b00);
    chk("ar_post_opB", opBmux_sel, 2'b00);
    chk("ar_post_opSr", opSrmux_sel, 2'b00);
    set_id(1, 3'd5, 1, 3'd5, 1, 3'd5, 1, 3'd2, 1, 0);
    chk("ar_post_stall", {1'b0, stall_id}, 2'b00);
    step(1);
    chk("ar_invalid_no_fwd", opAmux_sel, 2'b00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
